fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer sitting between instruction memory and the decoder. Owns the program counter, issues one instruction-memory read per instruction, presents the fetched word to the decoder over the ready/busy handshake, waits for the decoder to finish, then computes the next PC from the decoder's offset, jump-address and absolute-flag outputs. Strictly one instruction in flight; no prefetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16'd255, FETCH cycles without imem_ack before a timeout error (1..65535).

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- halt  in  1  1: do not start a new fetch.
- imem_req  out  1  read request, held high for the whole FETCH state.
- imem_addr  out  32  read address, equal to pc_counter.
- imem_ack  in  1  read complete; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instruction_data  out  32  latched instruction to the decoder.
- instruction_RDY_BSY  out  1  1: instruction_data valid for the decoder.
- decoder_rdy_bsy  in  1  decoder status, 1 ready / 0 busy.
- pc_offset  in  13  signed relative PC step from the decoder.
- pc_jump_address  in  32  absolute target from the decoder.
- pc_absolute_flag  in  1  1: use pc_jump_address.
- pc_counter  out  32  address of the current instruction.
- instr_count  out  32  retired-instruction counter.
- fetch_error  out  1  sticky error (misaligned target or timeout).

## Operation
- States: IDLE, FETCH, PRESENT, EXECUTE, UPDATE, HALT.
- IDLE:
  - If halt=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - imem_req=1.
  - On imem_ack=1: latch imem_rdata into instruction_data and go to PRESENT.
  - Otherwise increment wait_cnt (16-bit, cleared on FETCH entry).
  - When wait_cnt reaches MAX_WAIT with no ack: fetch_error<=1 and go to HALT.
  - If imem_ack arrives in the same cycle the limit is reached, the ack wins.
- PRESENT:
  - instruction_RDY_BSY=1.
  - The first cycle with decoder_rdy_bsy=0 counts as accept: go to EXECUTE and drop instruction_RDY_BSY.
- EXECUTE:
  - Wait for decoder_rdy_bsy=1, which means the instruction is complete.
  - pc_offset, pc_jump_address and pc_absolute_flag are sampled in that same cycle into next_pc; then go to UPDATE.
- next_pc arithmetic (all 32-bit, modulo 2^32, wrap at 32'hFFFF_FFFC+4 -> 0):
  - If pc_absolute_flag=1: next_pc = pc_jump_address with bit0 cleared.
  - Else if pc_offset = 0: next_pc = pc_counter + 4. A branch-to-self with offset 0 is therefore not supported.
  - Else: next_pc = pc_counter + sign_extend(pc_offset).
- UPDATE:
  - pc_counter <= next_pc; instr_count <= instr_count+1 (wraps).
  - If next_pc[1]=1: fetch_error<=1 and go to HALT. pc_counter still updates, so the faulting target is visible.
  - Else if halt=1: go to IDLE.
  - Else: go to FETCH.
- HALT: terminal. All outputs hold; only rst leaves this state.
- imem_ack outside FETCH is ignored.
- halt is sampled only in IDLE and UPDATE. It never aborts FETCH, PRESENT or EXECUTE.

## Timing
- Reset values:
  - pc_counter = imem_addr = RESET_PC.
  - imem_req = 0, instruction_data = 0, instruction_RDY_BSY = 0.
  - instr_count = 0, fetch_error = 0, wait_cnt = 0, state = IDLE.
- rst has priority over every transition. Asserting rst in any state, including mid-FETCH with an ack pending, returns to the reset values on the next edge; an ack in a reset cycle is discarded.
- After rst deasserts with halt=0, imem_req rises one cycle later.
- With zero-wait memory (ack in the first FETCH cycle), instruction_RDY_BSY rises the cycle after the FETCH cycle.
- Per-instruction overhead is FETCH(1+waits) + PRESENT(≥1) + EXECUTE(≥1) + UPDATE(1) cycles.
- Outputs are registered. instruction_data is stable from PRESENT entry until the next imem_ack.

## Test plan
- Reset, RESET_PC=0, halt=0, memory acks in 1 cycle with 32'h00500093, decoder takes 3 cycles, pc_offset=4 -> imem_req at cycle 1, instruction_RDY_BSY=1 with instruction_data=32'h00500093, pc_counter=4 after UPDATE, instr_count=1.
- Branch: pc_counter=32'h40, pc_offset=13'h1FF8 (-8) -> pc_counter=32'h38. With pc_offset=0 -> pc_counter=32'h44.
- Jump: pc_absolute_flag=1, pc_jump_address=32'h0000_1001 -> pc_counter=32'h1000, no error. pc_jump_address=32'h1002 -> fetch_error=1, state HALT, imem_req stays 0.
- Timeout: MAX_WAIT=4, imem_ack held 0 -> fetch_error=1 after 4 FETCH cycles. A variant with the ack in the 4th cycle -> no error, instruction presented.
- halt=1 during EXECUTE -> instruction completes, pc_counter and instr_count update, state IDLE with no imem_req. halt=0 -> fetch resumes the next cycle.
- Wrap and reset: pc_counter=32'hFFFF_FFFC, pc_offset=4 -> pc_counter=0. rst asserted in FETCH with imem_ack=1 -> all outputs return to reset values, instruction_data=0.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read per instruction,
// hands the word to the decoder and computes the next PC once the decoder completes.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [15:0] MAX_WAIT = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_data,
  output logic        instruction_RDY_BSY,
  input  logic        decoder_rdy_bsy,
  input  logic [12:0] pc_offset,
  input  logic [31:0] pc_jump_address,
  input  logic        pc_absolute_flag,
  output logic [31:0] pc_counter,
  output logic [31:0] instr_count,
  output logic        fetch_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PRESENT = 3'd2,
    EXECUTE = 3'd3,
    UPDATE  = 3'd4,
    HALT    = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] wait_cnt_r;
  logic [31:0] pc_r;
  logic [31:0] next_pc_r;
  logic [31:0] next_pc_s;
  logic [31:0] instr_data_r;
  logic [31:0] instr_count_r;
  logic        req_r;
  logic        rdy_r;
  logic        error_r;
  logic        req_s;
  logic        rdy_s;
  logic        timeout_s;

  // Last allowed FETCH cycle without an ack; an ack in that cycle still wins.
  assign timeout_s = (state_r == FETCH) && !imem_ack && (wait_cnt_r == (MAX_WAIT - 16'd1));

  // Next-PC arithmetic from the decoder's outputs.
  always_comb begin
    next_pc_s = pc_r + 32'd4;
    if (pc_absolute_flag) begin
      next_pc_s = pc_jump_address & 32'hFFFF_FFFE;
    end else if (pc_offset != 13'd0) begin
      next_pc_s = pc_r + {{19{pc_offset[12]}}, pc_offset};
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!halt) next_state_s = FETCH;
        else       next_state_s = IDLE;
      end
      FETCH: begin
        if (imem_ack)       next_state_s = PRESENT;
        else if (timeout_s) next_state_s = HALT;
        else                next_state_s = FETCH;
      end
      PRESENT: begin
        if (!decoder_rdy_bsy) next_state_s = EXECUTE;
        else                  next_state_s = PRESENT;
      end
      EXECUTE: begin
        if (decoder_rdy_bsy) next_state_s = UPDATE;
        else                 next_state_s = EXECUTE;
      end
      UPDATE: begin
        if (next_pc_r[1]) next_state_s = HALT;
        else if (halt)    next_state_s = IDLE;
        else              next_state_s = FETCH;
      end
      HALT:    next_state_s = HALT;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: handshake outputs follow the state being entered so they register cleanly.
  always_comb begin
    req_s = 1'b0;
    rdy_s = 1'b0;
    case (next_state_s)
      FETCH:   req_s = 1'b1;
      PRESENT: rdy_s = 1'b1;
      default: begin
        req_s = 1'b0;
        rdy_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r         <= 1'b0;
      rdy_r         <= 1'b0;
      wait_cnt_r    <= 16'd0;
      pc_r          <= RESET_PC;
      next_pc_r     <= RESET_PC;
      instr_data_r  <= 32'd0;
      instr_count_r <= 32'd0;
      error_r       <= 1'b0;
    end else begin
      req_r <= req_s;
      rdy_r <= rdy_s;
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            instr_data_r <= imem_rdata;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
            if (timeout_s) error_r <= 1'b1;
          end
        end
        EXECUTE: begin
          wait_cnt_r <= 16'd0;
          if (decoder_rdy_bsy) next_pc_r <= next_pc_s;
        end
        UPDATE: begin
          wait_cnt_r    <= 16'd0;
          pc_r          <= next_pc_r;
          instr_count_r <= instr_count_r + 32'd1;
          if (next_pc_r[1]) error_r <= 1'b1;
        end
        HALT: begin
          wait_cnt_r <= wait_cnt_r;
        end
        default: begin
          wait_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  assign imem_req            = req_r;
  assign imem_addr           = pc_r;
  assign pc_counter          = pc_r;
  assign instruction_data    = instr_data_r;
  assign instruction_RDY_BSY = rdy_r;
  assign instr_count         = instr_count_r;
  assign fetch_error         = error_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected words and PCs are queued when
// stimulus is driven and compared when the DUT presents them.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_data;
  logic        rdy;
  logic        decoder_rdy_bsy;
  logic [12:0] pc_offset;
  logic [31:0] pc_jump_address;
  logic        pc_absolute_flag;
  logic [31:0] pc_counter;
  logic [31:0] instr_count;
  logic        fetch_error;

  int          check_cnt = 0;
  int          error_cnt = 0;
  logic [31:0] exp_word_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_count;

  fetch_controller #(.RESET_PC(32'h0000_0000), .MAX_WAIT(16'd4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .halt                (halt),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ack            (imem_ack),
    .imem_rdata          (imem_rdata),
    .instruction_data    (instruction_data),
    .instruction_RDY_BSY (rdy),
    .decoder_rdy_bsy     (decoder_rdy_bsy),
    .pc_offset           (pc_offset),
    .pc_jump_address     (pc_jump_address),
    .pc_absolute_flag    (pc_absolute_flag),
    .pc_counter          (pc_counter),
    .instr_count         (instr_count),
    .fetch_error         (fetch_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_pc"},    pc_counter, 32'h0);
    check_value({tag, "_addr"},  imem_addr, 32'h0);
    check_value({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check_value({tag, "_data"},  instruction_data, 32'h0);
    check_value({tag, "_rdy"},   {31'd0, rdy}, 32'd0);
    check_value({tag, "_count"}, instr_count, 32'h0);
    check_value({tag, "_err"},   {31'd0, fetch_error}, 32'd0);
  endtask

  // One full instruction: fetch with 'waits' unacked cycles, decoder accept, 'busy' busy cycles, PC update.
  task automatic run_instr(input logic [31:0] word, input int waits, input int busy,
                           input logic [12:0] off, input logic absf, input logic [31:0] jaddr,
                           input logic halt_in_exec);
    int n;
    logic [31:0] exp_pc;
    logic [31:0] sext;
    n = 0;
    while (imem_req !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check_value("fetch_req", {31'd0, imem_req}, 32'd1);
    check_value("fetch_addr", imem_addr, model_pc);
    imem_ack = 1'b0;
    repeat (waits) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_word_q.push_back(word);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = ~word;
    check_value("rdy_up", {31'd0, rdy}, 32'd1);
    if (exp_word_q.size() > 0) check_value("instr_data", instruction_data, exp_word_q.pop_front());
    decoder_rdy_bsy = 1'b0;
    tick();
    check_value("rdy_down", {31'd0, rdy}, 32'd0);
    if (halt_in_exec) halt = 1'b1;
    repeat (busy) tick();
    decoder_rdy_bsy  = 1'b1;
    pc_offset        = off;
    pc_absolute_flag = absf;
    pc_jump_address  = jaddr;
    sext = {{19{off[12]}}, off};
    if (absf)              exp_pc = {jaddr[31:1], 1'b0};
    else if (off == 13'd0) exp_pc = model_pc + 32'd4;
    else                   exp_pc = model_pc + sext;
    exp_pc_q.push_back(exp_pc);
    tick();
    pc_offset        = 13'h0AA;
    pc_absolute_flag = 1'b1;
    pc_jump_address  = 32'h5555_5550;
    tick();
    pc_absolute_flag = 1'b0;
    pc_offset        = 13'd0;
    model_pc    = exp_pc;
    model_count = model_count + 32'd1;
    if (exp_pc_q.size() > 0) check_value("pc_update", pc_counter, exp_pc_q.pop_front());
    check_value("instr_count", instr_count, model_count);
    check_value("err_after_update", {31'd0, fetch_error}, {31'd0, exp_pc[1]});
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    decoder_rdy_bsy = 1'b1; pc_offset = 13'd0; pc_jump_address = 32'h0; pc_absolute_flag = 1'b0;
    model_pc = 32'h0; model_count = 32'h0;
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check_value("req_cycle1", {31'd0, imem_req}, 32'd1);

    // Basic sequence, branches and jumps.
    run_instr(32'h0050_0093, 0, 2, 13'd4, 1'b0, 32'h0, 1'b0);
    check_value("pc_first", pc_counter, 32'h4);
    run_instr(32'h1111_0001, 0, 0, 13'd0, 1'b1, 32'h0000_0041, 1'b0);
    run_instr(32'h2222_0002, 1, 1, 13'h1FF8, 1'b0, 32'h0, 1'b0);
    check_value("pc_back8", pc_counter, 32'h38);
    run_instr(32'h3333_0003, 0, 0, 13'd0, 1'b1, 32'h0000_0040, 1'b0);
    run_instr(32'h4444_0004, 0, 3, 13'd0, 1'b0, 32'h0, 1'b0);
    check_value("pc_off0", pc_counter, 32'h44);
    run_instr(32'h5555_0005, 0, 0, 13'd0, 1'b1, 32'h0000_1001, 1'b0);
    check_value("pc_jump", pc_counter, 32'h1000);

    // halt raised during EXECUTE: instruction retires, then IDLE without a request.
    run_instr(32'h6666_0006, 0, 2, 13'd8, 1'b0, 32'h0, 1'b1);
    check_value("halt_idle_req", {31'd0, imem_req}, 32'd0);
    tick(); tick();
    check_value("halt_hold_req", {31'd0, imem_req}, 32'd0);
    check_value("halt_hold_pc", pc_counter, 32'h1008);
    halt = 1'b0;
    tick();
    check_value("resume_req", {31'd0, imem_req}, 32'd1);

    // Ack in the last allowed fetch cycle, then wrap through the top of memory.
    run_instr(32'h7777_0007, 3, 0, 13'd0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_instr(32'h8888_0008, 0, 1, 13'd4, 1'b0, 32'h0, 1'b0);
    check_value("pc_wrap", pc_counter, 32'h0);

    // Reset in FETCH with an ack pending.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_reset_state("rst_fetch");
    rst = 1'b0; imem_ack = 1'b0;
    model_pc = 32'h0; model_count = 32'h0;
    tick();

    // Misaligned target: error, HALT, acks ignored.
    run_instr(32'h9999_0009, 0, 0, 13'd0, 1'b1, 32'h0000_1002, 1'b0);
    check_value("misalign_pc", pc_counter, 32'h1002);
    check_value("misalign_err", {31'd0, fetch_error}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick(); tick();
    imem_ack = 1'b0;
    check_value("halt_req", {31'd0, imem_req}, 32'd0);
    check_value("halt_data", instruction_data, 32'h9999_0009);
    check_value("halt_count", instr_count, 32'h1);

    // Timeout with no ack.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick(); tick(); tick();
    check_value("to_err_early", {31'd0, fetch_error}, 32'd0);
    check_value("to_req_early", {31'd0, imem_req}, 32'd1);
    tick();
    check_value("to_err", {31'd0, fetch_error}, 32'd1);
    check_value("to_req", {31'd0, imem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
